// File: rtl/multi_phase_pwm_dt.sv
`default_nettype none
// ============================================================================
// Module      : multi_phase_pwm_dt
// Description : N-channel complementary PWM generator with per-channel
//               dead-time insertion, edge- or centre-aligned counting and
//               shadow registers that switch only at the period boundary.
// Revision    : 1.0  initial release
// ============================================================================
module multi_phase_pwm_dt #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 16,
  parameter int DT_W  = 10
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Enable,
  input  logic                  CenterAligned,
  input  logic [CNT_W-1:0]      Period,
  input  logic [N_CH*CNT_W-1:0] Duty,
  input  logic [DT_W-1:0]       DeadTime,
  input  logic                  DeadTime_En,
  input  logic                  Interrupt_Enable,
  input  logic                  Interrupt_Clear,
  output logic [N_CH-1:0]       PWM_H,
  output logic [N_CH-1:0]       PWM_L,
  output logic [CNT_W-1:0]      Count,
  output logic                  Cycle_Start,
  output logic                  Interrupt_Active
);

  localparam logic [CNT_W-1:0] c_min_period = CNT_W'(2);

  // Active (shadowed) configuration
  logic [CNT_W-1:0] r_period;
  logic [DT_W-1:0]  r_dt;
  logic             r_center;

  // Counter state
  logic [CNT_W-1:0] r_count;
  logic             r_dir_down;
  logic             r_run;        // previous cycle was enabled
  logic             r_cycle_start;
  logic             r_irq;

  logic [CNT_W-1:0] w_period_eff;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_wrap;
  logic             w_boundary;
  logic             w_load;
  logic             w_dt_active;

  assign w_period_eff = (r_period < c_min_period) ? c_min_period : r_period;
  assign w_count_inc  = r_count + 1'b1;

  // Edge mode wraps after Period_eff-1; centre mode wraps when the down-count reaches 0.
  assign w_wrap = r_center ? (r_dir_down && (r_count <= CNT_W'(1)))
                           : (r_count >= (w_period_eff - 1'b1));

  // The first enabled cycle after a stop is also treated as a boundary.
  assign w_boundary  = Enable && (!r_run || w_wrap);
  assign w_load      = !Enable || w_boundary;
  assign w_dt_active = DeadTime_En && (r_dt != '0);

  // Up/down counter with direction flag; held at 0 counting up while stopped
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count    <= '0;
      r_dir_down <= 1'b0;
      r_run      <= 1'b0;
    end else if (!Enable) begin
      r_count    <= '0;
      r_dir_down <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_boundary) begin
        r_count    <= '0;
        r_dir_down <= 1'b0;
      end else if (!r_center) begin
        r_count <= w_count_inc;
      end else if (!r_dir_down) begin
        r_count <= w_count_inc;
        if (w_count_inc >= w_period_eff) begin
          r_dir_down <= 1'b1;
        end
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Shadow-to-active transfer of the shared configuration
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_period <= '0;
      r_dt     <= '0;
      r_center <= 1'b0;
    end else if (w_load) begin
      r_period <= Period;
      r_dt     <= DeadTime;
      r_center <= CenterAligned;
    end
  end

  // Boundary pulse and sticky interrupt flag (set has priority over clear)
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cycle_start <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_cycle_start <= w_boundary;
      if (w_boundary && Interrupt_Enable) begin
        r_irq <= 1'b1;
      end else if (Interrupt_Clear) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign Count            = r_count;
  assign Cycle_Start      = r_cycle_start;
  assign Interrupt_Active = r_irq;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_duty;
      logic [CNT_W-1:0] w_duty_clamp;
      logic             w_raw;
      logic             r_raw_d;
      logic [DT_W-1:0]  r_dt_cnt;
      logic             r_h;
      logic             r_l;

      assign w_duty_clamp = (r_duty > w_period_eff) ? w_period_eff : r_duty;

      // On the down slope the compare includes equality so the centre-aligned
      // pulse spans exactly 2*D cycles around the valley.
      assign w_raw = (w_duty_clamp == w_period_eff) ||
                     ((r_center && r_dir_down) ? (r_count <= w_duty_clamp)
                                               : (r_count <  w_duty_clamp));

      // Per-channel duty shadow register
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_duty <= '0;
        end else if (w_load) begin
          r_duty <= Duty[i*CNT_W +: CNT_W];
        end
      end

      // Dead-time insertion: any raw edge forces both sides low for r_dt cycles
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_raw_d  <= 1'b0;
          r_dt_cnt <= '0;
          r_h      <= 1'b0;
          r_l      <= 1'b0;
        end else if (!Enable || !r_run) begin
          r_raw_d  <= 1'b0;
          r_dt_cnt <= '0;
          r_h      <= 1'b0;
          r_l      <= 1'b0;
        end else begin
          r_raw_d <= w_raw;
          if (!w_dt_active) begin
            r_dt_cnt <= '0;
            r_h      <= w_raw;
            r_l      <= !w_raw;
          end else if (w_raw != r_raw_d) begin
            r_dt_cnt <= r_dt;
            r_h      <= 1'b0;
            r_l      <= 1'b0;
          end else if (r_dt_cnt > DT_W'(1)) begin
            r_dt_cnt <= r_dt_cnt - 1'b1;
            r_h      <= 1'b0;
            r_l      <= 1'b0;
          end else begin
            r_dt_cnt <= '0;
            r_h      <= w_raw;
            r_l      <= !w_raw;
          end
        end
      end

      assign PWM_H[i] = r_h;
      assign PWM_L[i] = r_l;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_pwm_dt.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_phase_pwm_dt
// Description : Directed testbench for multi_phase_pwm_dt; expected per-cycle
//               outputs are queued when a run starts and popped each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multi_phase_pwm_dt;

  localparam int N_CH  = 3;
  localparam int CNT_W = 16;
  localparam int DT_W  = 10;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic                  Enable;
  logic                  CenterAligned;
  logic [CNT_W-1:0]      Period;
  logic [N_CH*CNT_W-1:0] Duty;
  logic [DT_W-1:0]       DeadTime;
  logic                  DeadTime_En;
  logic                  Interrupt_Enable;
  logic                  Interrupt_Clear;
  logic [N_CH-1:0]       PWM_H;
  logic [N_CH-1:0]       PWM_L;
  logic [CNT_W-1:0]      Count;
  logic                  Cycle_Start;
  logic                  Interrupt_Active;

  multi_phase_pwm_dt #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .Enable           (Enable),
    .CenterAligned    (CenterAligned),
    .Period           (Period),
    .Duty             (Duty),
    .DeadTime         (DeadTime),
    .DeadTime_En      (DeadTime_En),
    .Interrupt_Enable (Interrupt_Enable),
    .Interrupt_Clear  (Interrupt_Clear),
    .PWM_H            (PWM_H),
    .PWM_L            (PWM_L),
    .Count            (Count),
    .Cycle_Start      (Cycle_Start),
    .Interrupt_Active (Interrupt_Active)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [N_CH-1:0]  h;
    logic [N_CH-1:0]  l;
    logic [CNT_W-1:0] cnt;
    logic             cs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   c_now    = 0;
  bit   last_raw [N_CH];
  int   stable   [N_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Before a run starts the raw waveform is considered to have been low forever.
  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      last_raw[ch] = 1'b0;
      stable[ch]   = 1000;
    end
    c_now = 0;
  endtask

  // Expected outputs for samples c_from..c_to of a run (sample 1 = first boundary).
  // An output side is on only once raw has held its level for dt+1 samples.
  task automatic push_seg(input int c_from, input int c_to, input int per, input bit centre,
                          input int d0, input int d1, input int d2,
                          input bit dt_en, input int dt);
    int   pe, len, q, qp;
    int   dv [N_CH];
    bit   raw;
    exp_t e;
    pe = (per < 2) ? 2 : per;
    len = centre ? 2 * pe : pe;
    dv[0] = (d0 > pe) ? pe : d0;
    dv[1] = (d1 > pe) ? pe : d1;
    dv[2] = (d2 > pe) ? pe : d2;
    for (int c = c_from; c <= c_to; c++) begin
      q     = (c - 1) % len;
      e.cnt = CNT_W'(centre ? ((q <= pe) ? q : len - q) : q);
      e.cs  = (q == 0);
      e.h   = '0;
      e.l   = '0;
      if (c >= 2) begin
        qp = (c - 2) % len;
        for (int ch = 0; ch < N_CH; ch++) begin
          raw = centre ? ((qp < dv[ch]) || (qp >= len - dv[ch])) : (qp < dv[ch]);
          if (raw == last_raw[ch]) stable[ch]++;
          else stable[ch] = 1;
          last_raw[ch] = raw;
          if (!dt_en || dt == 0) begin
            e.h[ch] = raw;
            e.l[ch] = !raw;
          end else begin
            e.h[ch] = raw && (stable[ch] >= dt + 1);
            e.l[ch] = !raw && (stable[ch] >= dt + 1);
          end
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic start_run(input int per, input bit centre, input int d0, input int d1,
                           input int d2, input int dt, input bit dt_en);
    @(negedge Clk);
    Enable        = 1'b0;
    Period        = CNT_W'(per);
    CenterAligned = centre;
    Duty          = {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    DeadTime      = DT_W'(dt);
    DeadTime_En   = dt_en;
    @(negedge Clk);
    Enable = 1'b1;
    model_reset();
  endtask

  task automatic run_check(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      c_now++;
      if (sb.size() == 0) begin
        n_errors++;
        $error("FAIL scoreboard_empty: observed=0 expected entries at sample %0d", c_now);
      end else begin
        e = sb.pop_front();
        chk($sformatf("pwm_h@%0d", c_now), 32'(PWM_H), 32'(e.h));
        chk($sformatf("pwm_l@%0d", c_now), 32'(PWM_L), 32'(e.l));
        chk($sformatf("count@%0d", c_now), 32'(Count), 32'(e.cnt));
        chk($sformatf("cycle_start@%0d", c_now), 32'(Cycle_Start), 32'(e.cs));
        chk($sformatf("hl_overlap@%0d", c_now), 32'(PWM_H & PWM_L), 32'(0));
      end
    end
  endtask

  initial begin
    Reset_n          = 1'b0;
    Enable           = 1'b0;
    CenterAligned    = 1'b0;
    Period           = '0;
    Duty             = '0;
    DeadTime         = '0;
    DeadTime_En      = 1'b0;
    Interrupt_Enable = 1'b0;
    Interrupt_Clear  = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_count", 32'(Count), 32'(0));
    chk("rst_pwm_h", 32'(PWM_H), 32'(0));
    chk("rst_pwm_l", 32'(PWM_L), 32'(0));
    chk("rst_cycle_start", 32'(Cycle_Start), 32'(0));
    chk("rst_irq", 32'(Interrupt_Active), 32'(0));
    Reset_n = 1'b1;

    // Edge aligned, no dead time
    start_run(10, 1'b0, 3, 5, 0, 0, 1'b0);
    push_seg(1, 30, 10, 1'b0, 3, 5, 0, 1'b0, 0);
    run_check(30);

    // Edge aligned, dead time 2
    start_run(10, 1'b0, 3, 5, 0, 2, 1'b1);
    push_seg(1, 30, 10, 1'b0, 3, 5, 0, 1'b1, 2);
    run_check(30);

    // Centre aligned, Period 8, Duty1 = 4, Duty0 full, Duty2 zero
    start_run(8, 1'b1, 8, 4, 0, 0, 1'b0);
    push_seg(1, 32, 8, 1'b1, 8, 4, 0, 1'b0, 0);
    run_check(32);

    // Mid-period duty change applies only after the next wrap
    start_run(10, 1'b0, 10, 0, 0, 0, 1'b0);
    push_seg(1, 11, 10, 1'b0, 10, 0, 0, 1'b0, 0);
    push_seg(12, 31, 10, 1'b0, 5, 0, 0, 1'b0, 0);
    run_check(5);
    Duty[CNT_W-1:0] = CNT_W'(5);
    run_check(26);

    // Duty2 = 0 and Duty2 = 0xFFFF with dead time enabled
    start_run(10, 1'b0, 4, 0, 0, 3, 1'b1);
    push_seg(1, 20, 10, 1'b0, 4, 0, 0, 1'b1, 3);
    run_check(20);
    start_run(10, 1'b0, 4, 0, 65535, 3, 1'b1);
    push_seg(1, 20, 10, 1'b0, 4, 0, 65535, 1'b1, 3);
    run_check(20);

    // Period below 2 clamps to 2
    start_run(1, 1'b0, 1, 2, 0, 0, 1'b0);
    push_seg(1, 8, 1, 1'b0, 1, 2, 0, 1'b0, 0);
    run_check(8);

    // Interrupt: set beats a held clear at the boundary, then clear, then re-arm
    Interrupt_Enable = 1'b1;
    Interrupt_Clear  = 1'b1;
    start_run(10, 1'b0, 5, 0, 0, 0, 1'b0);
    push_seg(1, 14, 10, 1'b0, 5, 0, 0, 1'b0, 0);
    run_check(1);
    chk("irq_set_wins", 32'(Interrupt_Active), 32'(1));
    run_check(1);
    chk("irq_cleared", 32'(Interrupt_Active), 32'(0));
    Interrupt_Clear = 1'b0;
    run_check(8);
    chk("irq_idle_mid_period", 32'(Interrupt_Active), 32'(0));
    run_check(1);
    chk("irq_second_boundary", 32'(Interrupt_Active), 32'(1));
    run_check(3);
    chk("irq_sticky", 32'(Interrupt_Active), 32'(1));

    // Asynchronous reset in the middle of a high pulse
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_pwm_h", 32'(PWM_H), 32'(0));
    chk("async_rst_pwm_l", 32'(PWM_L), 32'(0));
    chk("async_rst_count", 32'(Count), 32'(0));
    chk("async_rst_irq", 32'(Interrupt_Active), 32'(0));
    chk("async_rst_cycle_start", 32'(Cycle_Start), 32'(0));
    @(negedge Clk);
    Reset_n = 1'b1;
    Enable  = 1'b0;
    repeat (2) @(negedge Clk);
    chk("post_rst_disabled_h", 32'(PWM_H), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
